// File: rtl/mem_wb_stage_pkg.sv
// Shared types and helpers for the MEM/WB stage: access sizes, FSM states,
// byte-lane masks and the natural-alignment test.
package mem_wb_stage_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } mem_size_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    // Byte-enable pattern for an access of the given size at lane 0.
    function automatic logic [7:0] size_mask(input mem_size_t size);
        case (size)
            SZ_B:    return MASK_B;
            SZ_H:    return MASK_H;
            SZ_W:    return MASK_W;
            default: return MASK_D;
        endcase
    endfunction

    // An access is aligned when its low address bits are a multiple of its size.
    function automatic logic is_aligned(input logic [2:0] addr_lo, input mem_size_t size);
        case (size)
            SZ_B:    return 1'b1;
            SZ_H:    return (addr_lo[0] == 1'b0);
            SZ_W:    return (addr_lo[1:0] == 2'b00);
            default: return (addr_lo == 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_stage_lane_align.sv
// Byte-lane steering between the core and a 64-bit doubleword memory:
// stores are shifted into their lanes, loads are extracted and extended.
module mem_lane_align
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0]  addr_lo,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    input  logic [63:0] store_data,
    input  logic [63:0] rdata,
    output logic [7:0]  be,
    output logic [63:0] wdata,
    output logic [63:0] load_data
);

    logic [63:0] shifted;

    // Place store bytes and their enables at the addressed lanes.
    always_comb begin
        be    = size_mask(size) << addr_lo;
        wdata = store_data << {addr_lo, 3'b000};
    end

    // Bring the addressed bytes down to bit 0 and sign/zero-extend by size.
    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        load_data = shifted;
        case (size)
            SZ_B: load_data = is_unsigned ? {56'b0, shifted[7:0]}
                                          : {{56{shifted[7]}}, shifted[7:0]};
            SZ_H: load_data = is_unsigned ? {48'b0, shifted[15:0]}
                                          : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W: load_data = is_unsigned ? {32'b0, shifted[31:0]}
                                          : {{32{shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB register: performs the data-memory access over a
// req/ack handshake, stalls upstream while waiting, aborts on timeout and
// resolves the branch decision.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] ex_adder,
    input  logic        ex_zero,
    input  logic [63:0] ex_alu_result,
    input  logic [63:0] ex_read_data2,
    input  logic [4:0]  ex_rd,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_unsigned,
    input  logic        ex_memtoreg,
    input  logic        ex_regwrite,
    input  logic        ex_branch,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        stall,
    output logic        pc_src,
    output logic [63:0] branch_target,
    output logic [63:0] wb_read_data,
    output logic [63:0] wb_alu_result,
    output logic [4:0]  wb_rd,
    output logic        wb_memtoreg,
    output logic        wb_regwrite,
    output logic        wb_misalign,
    output logic        wb_bus_error
);

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt, next_cnt;
    mem_size_t        size;
    logic             access, aligned;
    logic             req_int, timeout_hit, misalign_hit;
    logic [7:0]       lane_be;
    logic [63:0]      load_data;

    assign size          = mem_size_t'(ex_mem_size);
    assign access        = ex_memread | ex_memwrite;
    assign aligned       = is_aligned(ex_alu_result[2:0], size);
    assign dmem_addr     = {ex_alu_result[63:3], 3'b000};
    assign branch_target = ex_adder;
    assign pc_src        = reset & ex_branch & ex_zero;

    mem_lane_align u_lane_align (
        .addr_lo     (ex_alu_result[2:0]),
        .size        (size),
        .is_unsigned (ex_mem_unsigned),
        .store_data  (ex_read_data2),
        .rdata       (dmem_rdata),
        .be          (lane_be),
        .wdata       (dmem_wdata),
        .load_data   (load_data)
    );

    // Decide the request, timeout and misalign conditions and the next FSM state.
    always_comb begin
        next_state   = state;
        next_cnt     = wait_cnt;
        req_int      = 1'b0;
        timeout_hit  = 1'b0;
        misalign_hit = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (aligned) begin
                        req_int = 1'b1;
                        if (!dmem_ack) begin
                            next_state = WAIT;
                            next_cnt   = CNT_W'(1);
                        end
                    end else begin
                        misalign_hit = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    req_int    = 1'b1;
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    next_state  = IDLE;
                    next_cnt    = '0;
                end else begin
                    req_int  = 1'b1;
                    next_cnt = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    assign dmem_req = reset & req_int;
    assign dmem_we  = dmem_req & ex_memwrite;
    assign dmem_be  = dmem_req ? lane_be : 8'h00;
    assign stall    = dmem_req & ~dmem_ack & ~timeout_hit;

    // FSM state and wait counter; an ack seen during reset is discarded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
        end
    end

    // MEM/WB boundary: bubbles while stalled or aborted, full load otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_read_data  <= '0;
            wb_alu_result <= '0;
            wb_rd         <= '0;
            wb_memtoreg   <= 1'b0;
            wb_regwrite   <= 1'b0;
            wb_misalign   <= 1'b0;
            wb_bus_error  <= 1'b0;
        end else begin
            wb_misalign  <= 1'b0;
            wb_bus_error <= 1'b0;
            if (stall) begin
                wb_memtoreg <= 1'b0;
                wb_regwrite <= 1'b0;
            end else if (timeout_hit) begin
                wb_memtoreg  <= 1'b0;
                wb_regwrite  <= 1'b0;
                wb_bus_error <= 1'b1;
            end else if (misalign_hit) begin
                wb_alu_result <= ex_alu_result;
                wb_rd         <= ex_rd;
                wb_memtoreg   <= 1'b0;
                wb_regwrite   <= 1'b0;
                wb_misalign   <= 1'b1;
            end else begin
                wb_read_data  <= load_data;
                wb_alu_result <= ex_alu_result;
                wb_rd         <= ex_rd;
                wb_memtoreg   <= ex_memtoreg;
                wb_regwrite   <= ex_regwrite;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage using a queue of expected writebacks.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] ex_adder, ex_alu_result, ex_read_data2, dmem_rdata;
    logic        ex_zero, ex_mem_unsigned, ex_memtoreg, ex_regwrite;
    logic        ex_branch, ex_memread, ex_memwrite, dmem_ack;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_mem_size;
    logic        dmem_req, dmem_we, stall, pc_src;
    logic [63:0] dmem_addr, dmem_wdata, branch_target, wb_read_data, wb_alu_result;
    logic [7:0]  dmem_be;
    logic [4:0]  wb_rd;
    logic        wb_memtoreg, wb_regwrite, wb_misalign, wb_bus_error;

    typedef struct {
        logic [63:0] alu;
        logic [4:0]  rd;
        logic [63:0] rdata;
        logic        memtoreg;
        logic        regwrite;
        logic        misalign;
        logic        bus_error;
        logic        chk_rdata;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    mem_wb_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .ex_adder(ex_adder), .ex_zero(ex_zero), .ex_alu_result(ex_alu_result),
        .ex_read_data2(ex_read_data2), .ex_rd(ex_rd), .ex_mem_size(ex_mem_size),
        .ex_mem_unsigned(ex_mem_unsigned), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_branch(ex_branch), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall), .pc_src(pc_src),
        .branch_target(branch_target), .wb_read_data(wb_read_data),
        .wb_alu_result(wb_alu_result), .wb_rd(wb_rd), .wb_memtoreg(wb_memtoreg),
        .wb_regwrite(wb_regwrite), .wb_misalign(wb_misalign), .wb_bus_error(wb_bus_error)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case the run wanders off.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_adder = '0; ex_zero = 0; ex_alu_result = '0; ex_read_data2 = '0;
        ex_rd = '0; ex_mem_size = 2'b00; ex_mem_unsigned = 0; ex_memtoreg = 0;
        ex_regwrite = 0; ex_branch = 0; ex_memread = 0; ex_memwrite = 0;
        dmem_ack = 0; dmem_rdata = '0;
    endtask

    // Independent byte-by-byte load model.
    function automatic logic [63:0] model_load(input logic [63:0] rd64, input int lo,
                                               input int sz, input logic uns);
        logic [63:0] r = '0;
        int nb = 1 << sz;
        for (int b = 0; b < nb; b++) r[8*b +: 8] = rd64[8*(lo+b) +: 8];
        if (!uns && sz != 3 && r[8*nb-1])
            for (int k = 8*nb; k < 64; k++) r[k] = 1'b1;
        return r;
    endfunction

    task automatic test_reset();
        reset = 0;
        idle_inputs();
        ex_memread = 1; ex_alu_result = 64'h200; ex_mem_size = 2'b10;
        ex_branch = 1; ex_zero = 1; ex_regwrite = 1; ex_rd = 5'd9; dmem_ack = 1;
        tick();
        tick();
        checks++; if ({dmem_req, dmem_we, stall, pc_src} !== 4'b0) begin
            failures++; $display("[TB] FAIL reset_comb: got %b expected 0000", {dmem_req, dmem_we, stall, pc_src}); end
        checks++; if (dmem_be !== 8'h00) begin
            failures++; $display("[TB] FAIL reset_be: got %h expected 00", dmem_be); end
        checks++; if ({wb_alu_result, wb_read_data, wb_rd, wb_memtoreg, wb_regwrite, wb_misalign, wb_bus_error} !== '0) begin
            failures++; $display("[TB] FAIL reset_wb: got alu=%h rd=%0d rw=%b expected zeros", wb_alu_result, wb_rd, wb_regwrite); end
        idle_inputs();
        reset = 1;
        tick();
    endtask

    task automatic test_alu_op();
        exp_t e;
        idle_inputs();
        ex_regwrite = 1; ex_rd = 5'd5; ex_alu_result = 64'h1234;
        sb.push_back('{64'h1234, 5'd5, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        #1;
        checks++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin
            failures++; $display("[TB] FAIL alu_stall: got stall=%b req=%b expected 0 0", stall, dmem_req); end
        tick();
        e = sb.pop_front();
        checks++; if (wb_alu_result !== e.alu || wb_rd !== e.rd) begin
            failures++; $display("[TB] FAIL alu_wb: got %h/%0d expected %h/%0d", wb_alu_result, wb_rd, e.alu, e.rd); end
        checks++; if (wb_regwrite !== e.regwrite || wb_memtoreg !== e.memtoreg) begin
            failures++; $display("[TB] FAIL alu_ctrl: got rw=%b m2r=%b expected %b %b", wb_regwrite, wb_memtoreg, e.regwrite, e.memtoreg); end
    endtask

    task automatic test_load_wait();
        exp_t e;
        int nstall = 0;
        idle_inputs();
        ex_memread = 1; ex_memtoreg = 1; ex_regwrite = 1; ex_rd = 5'd7;
        ex_alu_result = 64'h104; ex_mem_size = 2'b10;
        dmem_rdata = 64'h80000000_00000000;
        sb.push_back('{64'h104, 5'd7, 64'hFFFFFFFF_80000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        #1;
        checks++; if (dmem_req !== 1'b1 || dmem_addr !== 64'h100 || dmem_we !== 1'b0) begin
            failures++; $display("[TB] FAIL ldw_req: got req=%b addr=%h we=%b expected 1 100 0", dmem_req, dmem_addr, dmem_we); end
        for (int i = 0; i < 3; i++) begin
            if (stall === 1'b1) nstall++;
            tick();
            checks++; if (wb_regwrite !== 1'b0 || wb_memtoreg !== 1'b0) begin
                failures++; $display("[TB] FAIL ldw_bubble: got rw=%b m2r=%b expected 0 0", wb_regwrite, wb_memtoreg); end
        end
        checks++; if (nstall !== 3) begin
            failures++; $display("[TB] FAIL ldw_stall_cycles: got %0d expected 3", nstall); end
        dmem_ack = 1;
        #1;
        checks++; if (stall !== 1'b0 || dmem_req !== 1'b1) begin
            failures++; $display("[TB] FAIL ldw_ack: got stall=%b req=%b expected 0 1", stall, dmem_req); end
        tick();
        idle_inputs();
        e = sb.pop_front();
        checks++; if (wb_read_data !== e.rdata) begin
            failures++; $display("[TB] FAIL ldw_data: got %h expected %h", wb_read_data, e.rdata); end
        checks++; if (wb_memtoreg !== e.memtoreg || wb_regwrite !== e.regwrite || wb_rd !== e.rd) begin
            failures++; $display("[TB] FAIL ldw_ctrl: got m2r=%b rw=%b rd=%0d expected %b %b %0d", wb_memtoreg, wb_regwrite, wb_rd, e.memtoreg, e.regwrite, e.rd); end
    endtask

    task automatic test_store_half();
        exp_t e;
        idle_inputs();
        ex_memwrite = 1; ex_alu_result = 64'h106; ex_mem_size = 2'b01;
        ex_read_data2 = 64'hBEEF; dmem_ack = 1;
        sb.push_back('{64'h106, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        #1;
        checks++; if (dmem_be !== 8'hC0) begin
            failures++; $display("[TB] FAIL sth_be: got %h expected c0", dmem_be); end
        checks++; if (dmem_wdata[63:48] !== 16'hBEEF || dmem_we !== 1'b1) begin
            failures++; $display("[TB] FAIL sth_wdata: got %h we=%b expected beef 1", dmem_wdata[63:48], dmem_we); end
        checks++; if (stall !== 1'b0) begin
            failures++; $display("[TB] FAIL sth_stall: got %b expected 0", stall); end
        tick();
        idle_inputs();
        e = sb.pop_front();
        checks++; if (wb_alu_result !== e.alu || wb_regwrite !== e.regwrite) begin
            failures++; $display("[TB] FAIL sth_wb: got %h rw=%b expected %h %b", wb_alu_result, wb_regwrite, e.alu, e.regwrite); end
    endtask

    task automatic test_misalign();
        exp_t e;
        idle_inputs();
        ex_memread = 1; ex_memtoreg = 1; ex_regwrite = 1; ex_rd = 5'd9;
        ex_alu_result = 64'h103; ex_mem_size = 2'b11;
        sb.push_back('{64'h103, 5'd9, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        #1;
        checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin
            failures++; $display("[TB] FAIL mis_req: got req=%b stall=%b expected 0 0", dmem_req, stall); end
        tick();
        idle_inputs();
        e = sb.pop_front();
        checks++; if (wb_misalign !== e.misalign || wb_regwrite !== e.regwrite || wb_memtoreg !== e.memtoreg) begin
            failures++; $display("[TB] FAIL mis_wb: got mis=%b rw=%b m2r=%b expected %b %b %b", wb_misalign, wb_regwrite, wb_memtoreg, e.misalign, e.regwrite, e.memtoreg); end
        tick();
        checks++; if (wb_misalign !== 1'b0) begin
            failures++; $display("[TB] FAIL mis_pulse: got %b expected 0", wb_misalign); end
    endtask

    task automatic test_timeout();
        exp_t e;
        int nstall = 0;
        idle_inputs();
        ex_memread = 1; ex_memtoreg = 1; ex_regwrite = 1; ex_rd = 5'd4;
        ex_alu_result = 64'h108; ex_mem_size = 2'b10;
        sb.push_back('{64'h0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        #1;
        while (stall === 1'b1 && nstall < 20) begin
            nstall++;
            tick();
        end
        checks++; if (nstall !== 4) begin
            failures++; $display("[TB] FAIL to_stall_cycles: got %0d expected 4", nstall); end
        checks++; if (dmem_req !== 1'b0) begin
            failures++; $display("[TB] FAIL to_req_drop: got %b expected 0", dmem_req); end
        tick();
        idle_inputs();
        e = sb.pop_front();
        checks++; if (wb_bus_error !== e.bus_error || wb_regwrite !== e.regwrite || wb_memtoreg !== e.memtoreg) begin
            failures++; $display("[TB] FAIL to_wb: got be=%b rw=%b m2r=%b expected %b %b %b", wb_bus_error, wb_regwrite, wb_memtoreg, e.bus_error, e.regwrite, e.memtoreg); end
        tick();
        checks++; if (wb_bus_error !== 1'b0 || dmem_req !== 1'b0) begin
            failures++; $display("[TB] FAIL to_after: got be=%b req=%b expected 0 0", wb_bus_error, dmem_req); end
    endtask

    task automatic test_reset_mid_wait();
        idle_inputs();
        ex_memread = 1; ex_memtoreg = 1; ex_regwrite = 1; ex_rd = 5'd3;
        ex_alu_result = 64'h110; ex_mem_size = 2'b10;
        #1;
        checks++; if (stall !== 1'b1) begin
            failures++; $display("[TB] FAIL rmw_enter: got stall=%b expected 1", stall); end
        tick();
        reset = 0;
        dmem_ack = 1;
        #1;
        checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin
            failures++; $display("[TB] FAIL rmw_comb: got req=%b stall=%b expected 0 0", dmem_req, stall); end
        tick();
        checks++; if ({wb_alu_result, wb_rd, wb_regwrite, wb_memtoreg} !== '0) begin
            failures++; $display("[TB] FAIL rmw_wb: got alu=%h rd=%0d rw=%b expected zeros", wb_alu_result, wb_rd, wb_regwrite); end
        reset = 1;
        idle_inputs();
        ex_branch = 1; ex_zero = 1; ex_adder = 64'h40;
        #1;
        checks++; if (pc_src !== 1'b1 || branch_target !== 64'h40) begin
            failures++; $display("[TB] FAIL rmw_branch: got %b %h expected 1 40", pc_src, branch_target); end
        checks++; if (dmem_req !== 1'b0) begin
            failures++; $display("[TB] FAIL rmw_idle: got req=%b expected 0", dmem_req); end
        ex_zero = 0;
        #1;
        checks++; if (pc_src !== 1'b0) begin
            failures++; $display("[TB] FAIL rmw_not_taken: got %b expected 0", pc_src); end
        tick();
        idle_inputs();
    endtask

    task automatic test_back_to_back_loads();
        exp_t e;
        logic [63:0] pat = 64'hF1E2D3C4_85766758;
        int lo_t[7]  = '{0, 7, 6, 2, 4, 0, 0};
        int sz_t[7]  = '{0, 0, 1, 1, 2, 2, 3};
        int uns_t[7] = '{0, 1, 0, 1, 0, 1, 0};
        for (int i = 0; i < 7; i++) begin
            idle_inputs();
            ex_memread = 1; ex_memtoreg = 1; ex_regwrite = 1; ex_rd = 5'(i + 10);
            ex_alu_result = 64'h2000 + 64'(lo_t[i]);
            ex_mem_size = 2'(sz_t[i]); ex_mem_unsigned = uns_t[i][0];
            dmem_rdata = pat; dmem_ack = 1;
            sb.push_back('{64'h2000 + 64'(lo_t[i]), 5'(i + 10),
                           model_load(pat, lo_t[i], sz_t[i], uns_t[i][0]),
                           1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
            tick();
            e = sb.pop_front();
            checks++; if (wb_read_data !== e.rdata || wb_rd !== e.rd) begin
                failures++; $display("[TB] FAIL b2b_load%0d: got %h/%0d expected %h/%0d", i, wb_read_data, wb_rd, e.rdata, e.rd); end
        end
        idle_inputs();
        tick();
    endtask

    // Run all scenarios in order and report.
    initial begin
        idle_inputs();
        reset = 0;
        test_reset();
        test_alu_op();
        test_load_wait();
        test_store_half();
        test_misalign();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back_loads();
        checks++; if (sb.size() != 0) begin
            failures++; $display("[TB] FAIL scoreboard_drain: got %0d expected 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
